if_prefetch_queue: RTL

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/if_prefetch_queue_if.sv | 29 ++
 rtl/if_prefetch_queue.sv | 127 ++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue_if.sv
// Fetch-unit bundle: redirect inputs, instruction-memory request/response channel and IF/ID output.
interface if_prefetch_queue_if;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        id_redirect;
    logic [31:0] id_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;

    // master is the prefetch queue; slave is the surrounding pipeline and memory
    modport master (
        input  ex_redirect, ex_target, id_redirect, id_target,
               imem_ready, imem_rvalid, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc4, out_inst
    );

    modport slave (
        output ex_redirect, ex_target, id_redirect, id_target,
               imem_ready, imem_rvalid, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc4, out_inst
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: credit-limited in-order fetch, tag FIFO, redirect flush/discard.
// Define IFQ_BYPASS_EN to present a response on out_* in its arrival cycle when the queue is empty.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    if_prefetch_queue_if.master  bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned UW = CW + 1;

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] BLOCKED = 2'd1;
    localparam logic [1:0] REDIR   = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [31:0]   pc;
    logic [31:0]   q_inst  [DEPTH];
    logic [31:0]   q_pc4   [DEPTH];
    logic [31:0]   tag_pc4 [DEPTH];
    logic [PW-1:0] q_rd, q_wr, t_rd, t_wr;
    logic [CW-1:0] q_cnt, outst, discard;
    logic [CW-1:0] q_cnt_nxt, outst_nxt, discard_nxt;
    logic [UW-1:0] used_nxt;

    logic        redir, issue, resp_acc, resp_keep, byp, push, pop, credit_ok, q_nonempty;
    logic [31:0] redir_pc;

    assign redir      = bus.ex_redirect | bus.id_redirect;
    assign redir_pc   = bus.ex_redirect ? bus.ex_target : bus.id_target;
    assign q_nonempty = (q_cnt != '0);
    assign credit_ok  = (UW'(q_cnt) + UW'(outst)) < UW'(DEPTH);

    // No request during reset, in a redirect cycle, or without a free credit
    assign bus.imem_req  = reset & ~redir & (state != BLOCKED) & credit_ok;
    assign bus.imem_addr = pc;
    assign issue         = bus.imem_req & bus.imem_ready;

    // Responses with nothing outstanding are protocol errors and are ignored
    assign resp_acc  = bus.imem_rvalid & (outst != '0);
    assign resp_keep = resp_acc & (discard == '0) & ~redir;

`ifdef IFQ_BYPASS_EN
    assign byp           = resp_keep & ~q_nonempty & bus.out_ready;
    assign bus.out_valid = reset & ~redir & (q_nonempty | byp);
    assign bus.out_pc4   = byp ? tag_pc4[t_rd]  : q_pc4[q_rd];
    assign bus.out_inst  = byp ? bus.imem_rdata : q_inst[q_rd];
`else
    assign byp           = 1'b0;
    assign bus.out_valid = reset & ~redir & q_nonempty;
    assign bus.out_pc4   = q_pc4[q_rd];
    assign bus.out_inst  = q_inst[q_rd];
`endif

    assign push = resp_keep & ~byp;
    assign pop  = q_nonempty & ~redir & bus.out_ready;

    // Occupancy, outstanding and discard bookkeeping
    always_comb begin
        q_cnt_nxt   = q_cnt + CW'(push) - CW'(pop);
        outst_nxt   = outst + CW'(issue) - CW'(resp_acc);
        discard_nxt = discard;
        if (redir) begin
            q_cnt_nxt   = '0;
            discard_nxt = outst - CW'(resp_acc);
        end else if (resp_acc && (discard != '0)) begin
            discard_nxt = discard - CW'(1);
        end
        used_nxt = UW'(q_cnt_nxt) + UW'(outst_nxt);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (used_nxt >= UW'(DEPTH)) state_nxt = BLOCKED;
            BLOCKED: if (used_nxt <  UW'(DEPTH)) state_nxt = FETCH;
            REDIR:   state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
        if (redir) state_nxt = REDIR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            q_rd    <= '0;
            q_wr    <= '0;
            t_rd    <= '0;
            t_wr    <= '0;
            q_cnt   <= '0;
            outst   <= '0;
            discard <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_inst[i]  <= '0;
                q_pc4[i]   <= '0;
                tag_pc4[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            q_cnt   <= q_cnt_nxt;
            outst   <= outst_nxt;
            discard <= discard_nxt;

            if (redir)      pc <= redir_pc;
            else if (issue) pc <= pc + 32'd4;

            // Tag FIFO pairs each response, kept or dropped, with its request's pc+4
            if (issue) begin
                tag_pc4[t_wr] <= pc + 32'd4;
                t_wr          <= t_wr + PW'(1);
            end
            if (resp_acc) t_rd <= t_rd + PW'(1);

            if (push) begin
                q_inst[q_wr] <= bus.imem_rdata;
                q_pc4[q_wr]  <= tag_pc4[t_rd];
                q_wr         <= q_wr + PW'(1);
            end
            if (redir)    q_rd <= q_wr;
            else if (pop) q_rd <= q_rd + PW'(1);
        end
    end
endmodule
